// File: rtl/phase_sweep_ctrl.sv
// phase_sweep_ctrl: sweeps the phase-shifter delay from a clamped minimum to a
// clamped maximum in fixed steps. Each point is held for a programmed number of
// generator frames. The delay only updates on a frame boundary, so the shifted
// clock never sees a change in the middle of a period.
module phase_sweep_ctrl #(
   parameter int PERIOD  = 1250,
   parameter int DELAY_W = 11,
   parameter int DWELL_W = 16,
   parameter int STEP_W  = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      loop,
   input  logic signed [DELAY_W-1:0] delay_min,
   input  logic signed [DELAY_W-1:0] delay_max,
   input  logic        [STEP_W-1:0]  step,
   input  logic        [DWELL_W-1:0] dwell,
   output logic signed [DELAY_W-1:0] delay,
   output logic                      frame_tick,
   output logic                      point_valid,
   output logic        [15:0]        point_idx,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int CNT_W = $clog2(PERIOD + 1);
   localparam int EXT_W = DELAY_W + 2;
   localparam logic [CNT_W-1:0]          TC      = CNT_W'(PERIOD);
   localparam logic signed [DELAY_W-1:0] LIM     = DELAY_W'(PERIOD / 2 - 1);
   localparam logic signed [DELAY_W-1:0] D_ONE   = DELAY_W'(1);
   localparam logic [STEP_W-1:0]         STEP_1  = STEP_W'(1);
   localparam logic [DWELL_W-1:0]        DWELL_1 = DWELL_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_DWELL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Keep sampled limits inside half a generator period.
   function automatic logic signed [DELAY_W-1:0] clamp_d(input logic signed [DELAY_W-1:0] v);
      logic signed [DELAY_W-1:0] r;
      r = v;
      if (v > LIM) begin
         r = LIM;
      end else if (v < -LIM) begin
         r = -LIM;
      end
      return r;
   endfunction

   // The shifter cannot take a zero delay, so zero is substituted with +1.
   function automatic logic signed [DELAY_W-1:0] zfix(input logic signed [DELAY_W-1:0] v);
      return (v == '0) ? D_ONE : v;
   endfunction

   // Registered state
   state_t                     r_state;
   logic [CNT_W-1:0]           r_cnt;
   logic signed [DELAY_W-1:0]  r_min;
   logic signed [DELAY_W-1:0]  r_max;
   logic [STEP_W-1:0]          r_step;
   logic [DWELL_W-1:0]         r_dwell;
   logic                       r_loop;
   logic [DWELL_W-1:0]         r_dwell_cnt;
   logic signed [DELAY_W-1:0]  r_pos;      // unfixed sweep position (min + k*step)
   logic signed [DELAY_W-1:0]  r_delay;    // zero-fixed value driven to the shifter
   logic [15:0]                r_idx;
   logic                       r_pv;
   logic                       r_err;

   // Next-state values
   state_t                     w_state_next;
   logic signed [DELAY_W-1:0]  w_min_next;
   logic signed [DELAY_W-1:0]  w_max_next;
   logic [STEP_W-1:0]          w_step_next;
   logic [DWELL_W-1:0]         w_dwell_next;
   logic                       w_loop_next;
   logic [DWELL_W-1:0]         w_dwell_cnt_next;
   logic signed [DELAY_W-1:0]  w_pos_next;
   logic signed [DELAY_W-1:0]  w_delay_next;
   logic [15:0]                w_idx_next;
   logic                       w_pv_next;
   logic                       w_err_next;

   // Combinational helpers
   logic                       w_tick;
   logic                       w_cfg_err;
   logic                       w_start_ok;
   logic signed [EXT_W-1:0]    w_nxt;
   logic signed [EXT_W-1:0]    w_max_ext;
   logic                       w_nxt_fits;
   logic [15:0]                w_idx_inc;

   assign w_tick     = (r_cnt == TC);
   assign w_cfg_err  = (delay_min > delay_max);
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   // The next point is formed two bits wider than a delay, so min+k*step cannot wrap.
   assign w_nxt      = $signed({{2{r_pos[DELAY_W-1]}}, r_pos})
                     + $signed({{(EXT_W - STEP_W){1'b0}}, r_step});
   assign w_max_ext  = $signed({{2{r_max[DELAY_W-1]}}, r_max});
   assign w_nxt_fits = (w_nxt <= w_max_ext);
   assign w_idx_inc  = (r_idx == 16'hFFFF) ? r_idx : (r_idx + 16'd1);

   // Free-running frame counter 0..PERIOD, phase-matched to the shifter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Sweep state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_min       <= '0;
         r_max       <= '0;
         r_step      <= STEP_1;
         r_dwell     <= DWELL_1;
         r_loop      <= 1'b0;
         r_dwell_cnt <= DWELL_1;
         r_pos       <= D_ONE;
         r_delay     <= D_ONE;
         r_idx       <= '0;
         r_pv        <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_min       <= w_min_next;
         r_max       <= w_max_next;
         r_step      <= w_step_next;
         r_dwell     <= w_dwell_next;
         r_loop      <= w_loop_next;
         r_dwell_cnt <= w_dwell_cnt_next;
         r_pos       <= w_pos_next;
         r_delay     <= w_delay_next;
         r_idx       <= w_idx_next;
         r_pv        <= w_pv_next;
         r_err       <= w_err_next;
      end
   end

   // Next-state and datapath decisions. Abort overrides everything else.
   always_comb begin
      w_state_next     = r_state;
      w_min_next       = r_min;
      w_max_next       = r_max;
      w_step_next      = r_step;
      w_dwell_next     = r_dwell;
      w_loop_next      = r_loop;
      w_dwell_cnt_next = r_dwell_cnt;
      w_pos_next       = r_pos;
      w_delay_next     = r_delay;
      w_idx_next       = r_idx;
      w_pv_next        = 1'b0;
      w_err_next       = r_err;

      if (abort) begin
         w_state_next = S_IDLE;
         w_err_next   = 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (w_start_ok) begin
                  if (w_cfg_err) begin
                     // Bad range: report it and park in DONE without touching delay.
                     w_err_next   = 1'b1;
                     w_state_next = S_DONE;
                  end else begin
                     w_err_next   = 1'b0;
                     w_min_next   = clamp_d(delay_min);
                     w_max_next   = clamp_d(delay_max);
                     w_step_next  = (step == '0) ? STEP_1 : step;
                     w_dwell_next = (dwell == '0) ? DWELL_1 : dwell;
                     w_loop_next  = loop;
                     w_state_next = S_ARM;
                  end
               end
            end

            S_ARM: begin
               // Load the first point on a frame boundary.
               if (w_tick) begin
                  w_pos_next       = r_min;
                  w_delay_next     = zfix(r_min);
                  w_idx_next       = '0;
                  w_dwell_cnt_next = r_dwell;
                  w_pv_next        = 1'b1;
                  w_state_next     = S_DWELL;
               end
            end

            S_DWELL: begin
               if (w_tick) begin
                  if (r_dwell_cnt == DWELL_1) begin
                     if (w_nxt_fits) begin
                        w_pos_next       = w_nxt[DELAY_W-1:0];
                        w_delay_next     = zfix(w_nxt[DELAY_W-1:0]);
                        w_idx_next       = w_idx_inc;
                        w_dwell_cnt_next = r_dwell;
                        w_pv_next        = 1'b1;
                     end else if (r_loop) begin
                        w_pos_next       = r_min;
                        w_delay_next     = zfix(r_min);
                        w_idx_next       = '0;
                        w_dwell_cnt_next = r_dwell;
                        w_pv_next        = 1'b1;
                     end else begin
                        // Past the end: keep the last delay and finish.
                        w_state_next = S_DONE;
                     end
                  end else begin
                     w_dwell_cnt_next = r_dwell_cnt - DWELL_1;
                  end
               end
            end

            default: begin
               w_state_next = S_IDLE;
            end
         endcase
      end
   end

   assign delay       = r_delay;
   assign frame_tick  = w_tick;
   assign point_valid = r_pv;
   assign point_idx   = r_idx;
   assign busy        = (r_state == S_ARM) || (r_state == S_DWELL);
   assign done        = (r_state == S_DONE);
   assign err         = r_err;

endmodule

// File: doc/phase_sweep_ctrl.md
Name: phase_sweep_ctrl

Overview:
- Sequences the `delay` input of the phase-shift clock generator through a programmed sweep: from `delay_min` to `delay_max` in steps of `step`.
- Holds each value for `dwell` generator periods.
- Runs a frame counter matched to the generator's period. `delay` changes only at frame boundaries, so the shifted clock never sees a mid-period change.
- Sits between the configuration registers and the shifter; reports progress to the test/measurement logic.

Parameters:
PERIOD, 1250, terminal count of the frame counter (frame = PERIOD+1 clk cycles, matching the shifter)
DELAY_W, 11, width of signed delay values
DWELL_W, 16, width of the dwell count
STEP_W, 10, width of the unsigned step size

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begins sweep (ignored unless IDLE or DONE)
abort  in  1  level; returns to IDLE at next clk edge, highest priority after reset
loop  in  1  sampled at start; 1 = restart at delay_min after delay_max instead of finishing
delay_min  in  DELAY_W  signed sweep start, sampled at start
delay_max  in  DELAY_W  signed sweep end, sampled at start
step  in  STEP_W  unsigned increment, sampled at start; 0 is treated as 1
dwell  in  DWELL_W  frames per point, sampled at start; 0 is treated as 1
delay  out  DELAY_W  signed delay to shifter; never 0
frame_tick  out  1  one-cycle pulse when frame counter == PERIOD
point_valid  out  1  one-cycle pulse, first frame of each new point (coincides with frame counter == 0)
point_idx  out  16  index of current point, 0-based, saturates at 0xFFFF
busy  out  1  high in ARM/DWELL
done  out  1  high in DONE until start or abort
err  out  1  config error latched at start (delay_min > delay_max); cleared by next start

Behaviour:
- Reset (rst_n low, async):
  - outputs: delay=1, frame counter=0, point_idx=0.
  - all pulses, busy, done and err = 0.
  - state = IDLE.
- Frame counter:
  - free-runs 0..PERIOD in all states, wraps to 0.
  - frame_tick = (counter == PERIOD), combinational decode of the registered counter.
- Clamp: sampled delay_min/delay_max are clamped to ±(PERIOD/2-1) = ±624 before use.
- Zero rule: any computed delay of 0 is output as +1. This happens at the sweep start and at every step.
- States:
  - IDLE:
    - start with min <= max: latch config, go to ARM.
    - start with min > max: err=1, done=1, go to DONE; delay unchanged.
  - ARM: wait for frame_tick. In that cycle:
    - load delay = zfix(min), point_idx=0, dwell counter = dwell.
    - go to DWELL.
    - point_valid pulses on the following cycle (counter==0).
  - DWELL: decrement the dwell counter on each frame_tick. On the frame_tick where it reaches 1:
    - compute nxt = delay + step in DELAY_W+2 signed bits, so there is no overflow.
    - nxt <= max: delay=zfix(nxt), point_idx+1, reload dwell, stay in DWELL.
    - nxt > max, loop=1: delay=zfix(min), point_idx=0, reload dwell, stay in DWELL.
    - nxt > max, loop=0: go to DONE; delay holds the last value.
  - DONE:
    - done=1, busy=0.
    - start behaves as in IDLE; abort goes to IDLE.
- abort:
  - any state goes to IDLE on the next edge.
  - delay holds its current value; busy, done and err clear.
  - overrides a simultaneous start.
- start while busy: ignored.
- delay_max itself is always visited if reachable exactly. The last point is the largest min+k*step <= max.
- Reset mid-sweep: immediate return to reset values; no pulses are emitted.

Test Plan:
- Reset, then start with min=-10, max=20, step=10, dwell=2, loop=0 -> delay sequence -10,1,10,20 (0 replaced by 1), each held 2 frames (2502 clk); point_idx 0..3; done rises at 4th-point end; exactly 4 point_valid pulses.
- Changes occur only at frame boundaries: check delay transitions only in the cycle after frame_tick, with counter==0 at point_valid.
- min=5, max=5, step=0, dwell=0 -> single point delay=5 held 1 frame; done.
- min=-600, max=-590, step=7, loop=1 -> delay -600,-593,-600,-593,... with point_idx resetting to 0; abort mid-DWELL -> IDLE next edge, delay holds, busy=0.
- min=30, max=10 -> err=1, done=1 in cycle after start, busy never asserts; then a valid start clears err.
- Clamp: min=-900, max=900, step=624 -> delay -624,1,624 (0 replaced by 1), then done. Assert rst_n low during DWELL -> all outputs return to reset values asynchronously.
